// File: rtl/vx_operands_sched_pkg.sv
// Shared types for the operand scheduler: the flattened operand packet and
// the requester-index width helper.
package vx_operands_sched_pkg;

   typedef struct packed {
      logic [15:0] tag;
      logic [63:0] rs3_data;
      logic [63:0] rs2_data;
      logic [63:0] rs1_data;
      logic [6:0]  rd;
      logic        is_branch;
      logic [7:0]  op_type;
      logic [31:0] pc;
   } data_t;

   localparam int OPERANDS_W = $bits(data_t);

   // A single requester still needs a one-bit index port.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vx_operands_sched_sva.sv
// Handshake stability checks for the operand scheduler ports.
module vx_operands_sched_sva #(
   parameter int NUM_REQS  = 4,
   parameter int DATA_W    = 256,
   parameter int REQ_SEL_W = 2
) (
   input logic                         clk,
   input logic                         reset_n,
   input logic [NUM_REQS-1:0]          in_valid,
   input logic [NUM_REQS*DATA_W-1:0]   in_data,
   input logic [NUM_REQS-1:0]          in_ready,
   input logic                         out_valid,
   input logic [DATA_W-1:0]            out_data,
   input logic [REQ_SEL_W-1:0]         out_sel,
   input logic                         out_ready
);

   for (genvar i = 0; i < NUM_REQS; i++) begin : g_in_stable
      a_in_stable: assert property (@(posedge clk)
         (reset_n && in_valid[i] && !in_ready[i]) |=>
         (!reset_n || !in_valid[i] || $stable(in_data[i*DATA_W +: DATA_W])));
   end

   a_out_stable: assert property (@(posedge clk)
      (reset_n && out_valid && !out_ready) |=>
      (!reset_n || (out_valid && $stable(out_data) && $stable(out_sel))));

endmodule

// File: rtl/vx_rr_grant.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module vx_rr_grant #(
   parameter int NUM_REQS = 4,
   parameter int SEL_W    = 2
) (
   input  logic [NUM_REQS-1:0] req,
   input  logic [SEL_W-1:0]    ptr,
   output logic [NUM_REQS-1:0] grant,
   output logic [SEL_W-1:0]    grant_idx,
   output logic                any_grant
);

   localparam logic [SEL_W:0] NUM_REQS_W = (SEL_W + 1)'(NUM_REQS);

   logic [SEL_W:0]   sum_s;
   logic [SEL_W-1:0] cand_s;
   logic             hit_s;

   // Scan from ptr upward; the first hit locks out every later candidate.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      sum_s     = '0;
      cand_s    = '0;
      hit_s     = 1'b0;
      for (int k = 0; k < NUM_REQS; k++) begin
         sum_s          = {1'b0, ptr} + (SEL_W + 1)'(k);
         sum_s          = (sum_s >= NUM_REQS_W) ? (sum_s - NUM_REQS_W) : sum_s;
         cand_s         = sum_s[SEL_W-1:0];
         hit_s          = req[cand_s] & ~any_grant;
         grant[cand_s]  = grant[cand_s] | hit_s;
         grant_idx      = hit_s ? cand_s : grant_idx;
         any_grant      = any_grant | hit_s;
      end
   end

endmodule

// File: rtl/vx_operands_sched.sv
// Round-robin share of one operand dispatch port among NUM_REQS issue slices,
// with a registered output stage and per-slice branch hold.
module vx_operands_sched
   import vx_operands_sched_pkg::*;
#(
   parameter int NUM_REQS  = 4,
   parameter int DATA_W    = OPERANDS_W,
   parameter int REQ_SEL_W = sel_width(NUM_REQS)
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NUM_REQS-1:0]        in_valid,
   input  logic [NUM_REQS*DATA_W-1:0] in_data,
   input  logic [NUM_REQS-1:0]        in_is_branch,
   output logic [NUM_REQS-1:0]        in_ready,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_data,
   output logic [REQ_SEL_W-1:0]       out_sel,
   input  logic                       out_ready,
   input  logic                       br_done_valid,
   input  logic [REQ_SEL_W-1:0]       br_done_sel,
   output logic [NUM_REQS-1:0]        br_pending
);

   localparam logic [REQ_SEL_W-1:0] LAST_SEL = REQ_SEL_W'(NUM_REQS - 1);

   logic [NUM_REQS-1:0]  eligible_s;
   logic [NUM_REQS-1:0]  grant_s;
   logic [NUM_REQS-1:0]  br_set_s;
   logic [NUM_REQS-1:0]  br_clr_s;
   logic [NUM_REQS-1:0]  br_pending_r;
   logic [REQ_SEL_W-1:0] grant_idx_s;
   logic [REQ_SEL_W-1:0] rr_ptr_r;
   logic [REQ_SEL_W-1:0] out_sel_r;
   logic                 any_grant_s;
   logic                 load_s;
   logic                 xfer_s;
   logic                 out_valid_r;
   logic [DATA_W-1:0]    grant_data_s;
   logic [DATA_W-1:0]    out_data_r;
   logic [DATA_W-1:0]    slice_s [NUM_REQS];

   for (genvar i = 0; i < NUM_REQS; i++) begin : g_slice
      assign slice_s[i] = in_data[i*DATA_W +: DATA_W];
   end

   assign eligible_s = in_valid & ~br_pending_r;

   vx_rr_grant #(
      .NUM_REQS (NUM_REQS),
      .SEL_W    (REQ_SEL_W)
   ) u_rr_grant (
      .req       (eligible_s),
      .ptr       (rr_ptr_r),
      .grant     (grant_s),
      .grant_idx (grant_idx_s),
      .any_grant (any_grant_s)
   );

   // The output register can take a new packet when empty or draining this cycle.
   assign load_s       = ~out_valid_r | out_ready;
   assign xfer_s       = any_grant_s & load_s & reset_n;
   assign in_ready     = grant_s & {NUM_REQS{load_s & reset_n}};
   assign grant_data_s = slice_s[grant_idx_s];
   assign br_set_s     = grant_s & in_is_branch & {NUM_REQS{xfer_s}};

   // Decode the resolution pulse; out-of-range slice numbers match nothing.
   always_comb begin
      br_clr_s = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         br_clr_s[i] = br_done_valid & (br_done_sel == REQ_SEL_W'(i));
      end
   end

   // Output stage, round-robin pointer and branch-hold flags.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_valid_r  <= 1'b0;
         out_data_r   <= '0;
         out_sel_r    <= '0;
         rr_ptr_r     <= '0;
         br_pending_r <= '0;
      end else begin
         if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= grant_data_s;
            out_sel_r   <= grant_idx_s;
            rr_ptr_r    <= (grant_idx_s == LAST_SEL) ? '0 : (grant_idx_s + REQ_SEL_W'(1));
         end else if (out_ready) begin
            out_valid_r <= 1'b0;
         end
         br_pending_r <= (br_pending_r & ~br_clr_s) | br_set_s;
      end
   end

   assign out_valid  = out_valid_r;
   assign out_data   = out_data_r;
   assign out_sel    = out_sel_r;
   assign br_pending = br_pending_r;

   vx_operands_sched_sva #(
      .NUM_REQS  (NUM_REQS),
      .DATA_W    (DATA_W),
      .REQ_SEL_W (REQ_SEL_W)
   ) u_sva (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid_r),
      .out_data  (out_data_r),
      .out_sel   (out_sel_r),
      .out_ready (out_ready)
   );

endmodule

// File: tb/tb_vx_operands_sched.sv
// Directed bench for vx_operands_sched: a 4-slice instance for arbitration,
// backpressure, branch hold and reset, plus a 5-slice instance for out-of-range resolution.
module tb_vx_operands_sched;

   logic          clk;
   logic          reset_n;
   logic [3:0]    in_valid;
   logic [1023:0] in_data;
   logic [3:0]    in_is_branch;
   logic [3:0]    in_ready;
   logic          out_valid;
   logic [255:0]  out_data;
   logic [1:0]    out_sel;
   logic          out_ready;
   logic          br_done_valid;
   logic [1:0]    br_done_sel;
   logic [3:0]    br_pending;

   logic [4:0]    v5, b5, rdy5, pend5;
   logic [159:0]  d5;
   logic          ov5, ordy5, bv5;
   logic [31:0]   od5;
   logic [2:0]    os5, bs5;

   int            checks;
   int            errors;
   int            cnt [4];
   logic [255:0]  hold_data;
   logic [1:0]    hold_sel;

   vx_operands_sched #(.NUM_REQS(4), .DATA_W(256)) u_dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_is_branch  (in_is_branch),
      .in_ready      (in_ready),
      .out_valid     (out_valid),
      .out_data      (out_data),
      .out_sel       (out_sel),
      .out_ready     (out_ready),
      .br_done_valid (br_done_valid),
      .br_done_sel   (br_done_sel),
      .br_pending    (br_pending)
   );

   vx_operands_sched #(.NUM_REQS(5), .DATA_W(32)) u_dut5 (
      .clk           (clk),
      .reset_n       (reset_n),
      .in_valid      (v5),
      .in_data       (d5),
      .in_is_branch  (b5),
      .in_ready      (rdy5),
      .out_valid     (ov5),
      .out_data      (od5),
      .out_sel       (os5),
      .out_ready     (ordy5),
      .br_done_valid (bv5),
      .br_done_sel   (bs5),
      .br_pending    (pend5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [255:0] mk_pkt(input int s, input int n);
      logic [31:0] w;
      w = {8'(s + 1), 24'(n)};
      return {8{w}};
   endfunction

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One cycle: drive, check the accept vector, clock, then check the registered outputs.
   task automatic step(input logic [3:0] v, input logic [3:0] br, input logic ordy,
                       input logic bv, input logic [1:0] bs,
                       input logic [3:0] exp_rdy, input logic exp_ov, input logic [3:0] exp_pend);
      in_valid      = v;
      in_is_branch  = br;
      out_ready     = ordy;
      br_done_valid = bv;
      br_done_sel   = bs;
      for (int i = 0; i < 4; i++) in_data[i*256 +: 256] = mk_pkt(i, cnt[i]);
      #1;
      check("in_ready", 256'(in_ready), 256'(exp_rdy));
      @(posedge clk);
      if (!reset_n) begin
         hold_data = '0;
         hold_sel  = 2'd0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (exp_rdy[i]) begin
               hold_data = mk_pkt(i, cnt[i]);
               hold_sel  = 2'(i);
               cnt[i]++;
            end
         end
      end
      #1;
      check("out_valid", 256'(out_valid), 256'(exp_ov));
      check("out_sel", 256'(out_sel), 256'(hold_sel));
      check("out_data", out_data, hold_data);
      check("br_pending", 256'(br_pending), 256'(exp_pend));
   endtask

   initial begin
      checks = 0; errors = 0;
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      hold_data = '0; hold_sel = 2'd0;
      reset_n = 1'b0;
      in_valid = 4'h0; in_is_branch = 4'h0; in_data = '0;
      out_ready = 1'b0; br_done_valid = 1'b0; br_done_sel = 2'd0;
      v5 = 5'b0; b5 = 5'b0; ordy5 = 1'b1; bv5 = 1'b0; bs5 = 3'd0;
      for (int i = 0; i < 5; i++) d5[i*32 +: 32] = 32'hA5A5_0000 + 32'(i);

      // reset with every slice requesting
      step(4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000);
      step(4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000);
      reset_n = 1'b1;
      // fairness 0,1,2,3,0,1
      step(4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 4'b0000);
      step(4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 4'b0000);
      step(4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 4'b0000);
      step(4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b1, 4'b0000);
      step(4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 4'b0000);
      step(4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 4'b0000);
      // backpressure: five stalled cycles, then resume at slice 2
      for (int k = 0; k < 5; k++) step(4'hF, 4'h0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000);
      step(4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 4'b0000);
      step(4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b1, 4'b0000);
      step(4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000);
      // branch hold on slice 2: sequence 3,0,1,3 then release
      step(4'b0100, 4'b0100, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 4'b0100);
      step(4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b1, 4'b0100);
      step(4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 4'b0100);
      step(4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 4'b0100);
      step(4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b1, 4'b0100);
      step(4'hF, 4'h0, 1'b1, 1'b1, 2'd2, 4'b0001, 1'b1, 4'b0000);
      step(4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 4'b0000);
      step(4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 4'b0000);
      // resolution of a non-pending slice, then set-1 with clear-3 together
      step(4'b1000, 4'b1000, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b1, 4'b1000);
      step(4'h0, 4'h0, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b0, 4'b1000);
      step(4'b0010, 4'b0010, 1'b1, 1'b1, 2'd3, 4'b0010, 1'b1, 4'b0010);
      step(4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 4'b0010);
      step(4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b1, 4'b0010);
      step(4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 4'b0010);
      step(4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 4'b0010);
      step(4'h0, 4'h0, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b0, 4'b0000);
      // sparse: only slice 3, pointer wraps to 0
      step(4'b1000, 4'h0, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b1, 4'b0000);
      step(4'b1000, 4'h0, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b1, 4'b0000);
      step(4'b0001, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 4'b0000);
      // reset while a packet is held and a branch is pending
      step(4'b0100, 4'b0100, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 4'b0100);
      reset_n = 1'b0;
      step(4'hF, 4'h0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000);
      reset_n = 1'b1;
      step(4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 4'b0000);
      step(4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000);

      // five-slice instance: branch on slice 4, out-of-range resolutions ignored
      v5 = 5'b10000; b5 = 5'b10000;
      #1;
      check("rdy5_grant", 256'(rdy5), 256'(5'b10000));
      @(posedge clk); #1;
      check("ov5", 256'(ov5), 256'(1'b1));
      check("os5", 256'(os5), 256'(3'd4));
      check("od5", 256'(od5), 256'(32'hA5A5_0004));
      check("pend5_set", 256'(pend5), 256'(5'b10000));
      b5 = 5'b0; bv5 = 1'b1; bs5 = 3'd5;
      #1;
      check("rdy5_held", 256'(rdy5), 256'(5'b00000));
      @(posedge clk); #1;
      check("pend5_sel5", 256'(pend5), 256'(5'b10000));
      v5 = 5'b0; bs5 = 3'd7;
      @(posedge clk); #1;
      check("pend5_sel7", 256'(pend5), 256'(5'b10000));
      bs5 = 3'd4;
      @(posedge clk); #1;
      check("pend5_clr", 256'(pend5), 256'(5'b00000));
      bv5 = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
